// File: rtl/eeg_io_width_adapter.sv
// rtl/eeg_io_width_adapter.sv - pad/core width adapter: packs narrow pad beats into core words, serialises core words to pad beats.
// Optional bring-up loopback (hold register -> output serialiser) enabled by EEG_IO_LOOPBACK_EN.
module eeg_io_width_adapter #(
  parameter int PAD_DW      = 8,
  parameter int CORE_DW     = 32,
  parameter int PAD_OUT_DW  = 8,
  parameter int CORE_OUT_DW = 32,
  localparam int IR = CORE_DW / PAD_DW,
  localparam int OR = CORE_OUT_DW / PAD_OUT_DW,
  localparam int CW = $clog2(IR + 1)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   pad_dat_vld,
  input  logic                   pad_dat_lst,
  input  logic                   pad_dat_cmd,
  input  logic [PAD_DW-1:0]      pad_dat_dat,
  output logic                   pad_dat_rdy,
  output logic                   core_dat_vld,
  output logic                   core_dat_lst,
  output logic                   core_dat_cmd,
  output logic [CORE_DW-1:0]     core_dat_dat,
  output logic [CW-1:0]          core_dat_cnt,
  input  logic                   core_dat_rdy,
  input  logic                   core_out_vld,
  input  logic                   core_out_lst,
  input  logic [CORE_OUT_DW-1:0] core_out_dat,
  output logic                   core_out_rdy,
  output logic                   pad_out_vld,
  output logic                   pad_out_lst,
  output logic [PAD_OUT_DW-1:0]  pad_out_dat,
`ifdef EEG_IO_LOOPBACK_EN
  input  logic                   pad_out_rdy,
  input  logic                   loopback
`else
  input  logic                   pad_out_rdy
`endif
);

  localparam int IW   = (IR > 1) ? $clog2(IR) : 1;
  localparam int OW   = (OR > 1) ? $clog2(OR) : 1;
  localparam int MINW = (CORE_DW < CORE_OUT_DW) ? CORE_DW : CORE_OUT_DW;

  logic [CORE_DW-1:0]     asm_q, asm_d;
  logic [IW-1:0]          idx_q, idx_d;
  logic                   asm_cmd_q, asm_cmd_d;
  logic                   asm_lst_q, asm_lst_d;
  logic                   asm_pend_q, asm_pend_d;
  logic [CW-1:0]          asm_cnt_q, asm_cnt_d;

  logic                   hold_vld_q, hold_vld_d;
  logic [CORE_DW-1:0]     hold_dat_q, hold_dat_d;
  logic [CW-1:0]          hold_cnt_q, hold_cnt_d;
  logic                   hold_lst_q, hold_lst_d;
  logic                   hold_cmd_q, hold_cmd_d;

  logic [CORE_OUT_DW-1:0] sh_q, sh_d;
  logic [OW-1:0]          b_q, b_d;
  logic                   busy_q, busy_d;
  logic                   wlst_q, wlst_d;

  logic                   lb;
  logic                   beat_acc, beat_done, idx_last;
  logic [CORE_DW-1:0]     beat_word;
  logic                   beat_cmd;
  logic [CW-1:0]          beat_cnt;
  logic                   hold_rel, hold_free;
  logic                   ser_last, ser_rdy, ser_load;
  logic                   ser_in_vld, ser_in_lst;
  logic [CORE_OUT_DW-1:0] ser_in_dat, lb_dat;

`ifdef EEG_IO_LOOPBACK_EN
  assign lb = loopback;
`else
  assign lb = 1'b0;
`endif

  always_comb begin
    lb_dat = '0;
    lb_dat[MINW-1:0] = hold_dat_q[MINW-1:0];
  end

  assign beat_acc  = pad_dat_vld & ~asm_pend_q;
  assign idx_last  = (idx_q == IW'(IR - 1));
  assign beat_done = beat_acc & (idx_last | pad_dat_lst);
  assign beat_cmd  = (idx_q == '0) ? pad_dat_cmd : asm_cmd_q;
  assign beat_cnt  = CW'(idx_q) + CW'(1);

  // Clearing on the first beat guarantees zeroed upper slices on a short word.
  always_comb begin
    beat_word = (idx_q == '0) ? '0 : asm_q;
    for (int i = 0; i < IR; i++) begin
      if (idx_q == IW'(i)) beat_word[i*PAD_DW +: PAD_DW] = pad_dat_dat;
    end
  end

  assign ser_last   = (b_q == OW'(OR - 1));
  assign ser_rdy    = ~busy_q | (pad_out_rdy & ser_last);
  assign ser_in_vld = lb ? hold_vld_q : core_out_vld;
  assign ser_in_lst = lb ? hold_lst_q : core_out_lst;
  assign ser_in_dat = lb ? lb_dat : core_out_dat;
  assign ser_load   = ser_in_vld & ser_rdy;

  assign hold_rel  = hold_vld_q & (lb ? ser_rdy : core_dat_rdy);
  assign hold_free = ~hold_vld_q | hold_rel;

  always_comb begin
    asm_d      = asm_q;
    idx_d      = idx_q;
    asm_cmd_d  = asm_cmd_q;
    asm_lst_d  = asm_lst_q;
    asm_pend_d = asm_pend_q;
    asm_cnt_d  = asm_cnt_q;
    hold_vld_d = hold_vld_q;
    hold_dat_d = hold_dat_q;
    hold_cnt_d = hold_cnt_q;
    hold_lst_d = hold_lst_q;
    hold_cmd_d = hold_cmd_q;

    if (hold_rel) begin
      hold_vld_d = 1'b0;
      hold_dat_d = '0;
      hold_cnt_d = '0;
      hold_lst_d = 1'b0;
      hold_cmd_d = 1'b0;
    end

    if (asm_pend_q && hold_free) begin
      asm_pend_d = 1'b0;
      hold_vld_d = 1'b1;
      hold_dat_d = asm_q;
      hold_cnt_d = asm_cnt_q;
      hold_lst_d = asm_lst_q;
      hold_cmd_d = asm_cmd_q;
    end else if (beat_done) begin
      idx_d = '0;
      if (hold_free) begin
        hold_vld_d = 1'b1;
        hold_dat_d = beat_word;
        hold_cnt_d = beat_cnt;
        hold_lst_d = pad_dat_lst;
        hold_cmd_d = beat_cmd;
      end else begin
        asm_pend_d = 1'b1;
        asm_d      = beat_word;
        asm_cnt_d  = beat_cnt;
        asm_lst_d  = pad_dat_lst;
        asm_cmd_d  = beat_cmd;
      end
    end else if (beat_acc) begin
      idx_d     = idx_q + IW'(1);
      asm_d     = beat_word;
      asm_cmd_d = beat_cmd;
    end
  end

  // A load in the same cycle as the final beat overrides the shift/idle update.
  always_comb begin
    sh_d   = sh_q;
    b_d    = b_q;
    busy_d = busy_q;
    wlst_d = wlst_q;
    if (busy_q && pad_out_rdy) begin
      if (ser_last) begin
        busy_d = 1'b0;
        b_d    = '0;
      end else begin
        b_d  = b_q + OW'(1);
        sh_d = sh_q >> PAD_OUT_DW;
      end
    end
    if (ser_load) begin
      busy_d = 1'b1;
      b_d    = '0;
      sh_d   = ser_in_dat;
      wlst_d = ser_in_lst;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      asm_q      <= '0;
      idx_q      <= '0;
      asm_cmd_q  <= 1'b0;
      asm_lst_q  <= 1'b0;
      asm_pend_q <= 1'b0;
      asm_cnt_q  <= '0;
      hold_vld_q <= 1'b0;
      hold_dat_q <= '0;
      hold_cnt_q <= '0;
      hold_lst_q <= 1'b0;
      hold_cmd_q <= 1'b0;
      sh_q       <= '0;
      b_q        <= '0;
      busy_q     <= 1'b0;
      wlst_q     <= 1'b0;
    end else begin
      asm_q      <= asm_d;
      idx_q      <= idx_d;
      asm_cmd_q  <= asm_cmd_d;
      asm_lst_q  <= asm_lst_d;
      asm_pend_q <= asm_pend_d;
      asm_cnt_q  <= asm_cnt_d;
      hold_vld_q <= hold_vld_d;
      hold_dat_q <= hold_dat_d;
      hold_cnt_q <= hold_cnt_d;
      hold_lst_q <= hold_lst_d;
      hold_cmd_q <= hold_cmd_d;
      sh_q       <= sh_d;
      b_q        <= b_d;
      busy_q     <= busy_d;
      wlst_q     <= wlst_d;
    end
  end

  assign pad_dat_rdy  = ~asm_pend_q;
  assign core_dat_vld = hold_vld_q & ~lb;
  assign core_dat_dat = hold_dat_q;
  assign core_dat_cnt = hold_cnt_q;
  assign core_dat_lst = hold_lst_q;
  assign core_dat_cmd = hold_cmd_q;
  assign core_out_rdy = ser_rdy & ~lb;
  assign pad_out_vld  = busy_q;
  assign pad_out_dat  = sh_q[PAD_OUT_DW-1:0];
  assign pad_out_lst  = busy_q & wlst_q & ser_last;

endmodule
